irq_sequencer: RTL and testbench

- Memory-mapped interrupt scheduler for the 16 peripheral interrupt lines.
- Latches line edges into a pending register, masks them with an enable register, and picks one winner by fixed or rotating priority.
- Presents the winner's vector to the CPU and holds it through an ack / in-service / end-of-interrupt (EOI) handshake.
- Sits between the peripherals and the CPU interrupt input, on the shared 16-bit peripheral bus.

---
 rtl/irq_pkg.sv | 10 +
 rtl/irq_prio_pick.sv | 22 ++
 rtl/irq_sequencer.sv | 93 +++++++++
 tb/tb_irq_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared register offsets, FSM encoding and STATUS layout for irq_sequencer
package irq_pkg;
  localparam logic [15:0] REG_PENDING = 16'd0;
  localparam logic [15:0] REG_ENABLE  = 16'd1;
  localparam logic [15:0] REG_STATUS  = 16'd2;
  localparam logic [15:0] REG_EOI     = 16'd3;
  localparam int STAT_INSVC = 15;
  localparam int STAT_REQ   = 14;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_e;
endpackage

// File: rtl/irq_prio_pick.sv
// irq_prio_pick: combinational 16-line fixed or rotating priority picker
module irq_prio_pick #(
  parameter bit ROTATE = 1'b0
) (
  input  logic [15:0] i_cand,
  input  logic [3:0]  i_start,
  output logic        o_valid,
  output logic [3:0]  o_index
);
  logic [3:0] base, j;
  assign base = ROTATE ? i_start : 4'd0;
  assign o_valid = |i_cand;
  // scan from farthest to nearest offset so the nearest set line is assigned last
  always_comb begin
    o_index = 4'd0;
    j = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      j = base + 4'(k);
      if (i_cand[j]) o_index = j;
    end
  end
endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: memory-mapped interrupt scheduler with ack/service/EOI handshake
module irq_sequencer
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0420,
  parameter bit          ROTATE    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  input  logic [15:0] i_lines,
  input  logic        i_ack,
  output logic        o_int,
  output logic [3:0]  o_vector
);
  logic [15:0] pending_q, pending_d, enable_q, enable_d, prev_q, data_q, data_d;
  logic [15:0] cand, clr, status;
  logic [3:0]  vec_q, vec_d, last_q, last_d, win;
  logic        win_valid, wr_pend, wr_en, wr_eoi;
  state_e      state_q, state_d;
  assign wr_pend = i_we && i_addr == BASE_ADDR + REG_PENDING;
  assign wr_en   = i_we && i_addr == BASE_ADDR + REG_ENABLE;
  assign wr_eoi  = i_we && i_addr == BASE_ADDR + REG_EOI;
  assign cand    = pending_q & enable_q;
  assign status  = {state_q == SERVICE, state_q == REQ, 10'd0, vec_q};
  irq_prio_pick #(.ROTATE(ROTATE)) u_pick (
    .i_cand (cand),
    .i_start(last_q + 4'd1),
    .o_valid(win_valid),
    .o_index(win)
  );
  // register file: edge capture into pending (set beats clear), enable, registered read mux
  always_comb begin
    clr = (wr_pend ? i_data : 16'd0) | ((state_q == REQ && i_ack) ? 16'd1 << vec_q : 16'd0);
    pending_d = (pending_q & ~clr) | (i_lines & ~prev_q);
    enable_d = wr_en ? i_data : enable_q;
    data_d = i_addr == BASE_ADDR + REG_PENDING ? pending_q :
             i_addr == BASE_ADDR + REG_ENABLE  ? enable_q  :
             i_addr == BASE_ADDR + REG_STATUS  ? status    : 16'd0;
  end
  // handshake FSM: vector is latched on request and cleared whenever we fall back to IDLE
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (win_valid) begin
        state_d = REQ;
        vec_d = win;
      end
      REQ: if (i_ack) state_d = SERVICE;
        else if (!cand[vec_q]) begin
          state_d = IDLE;
          vec_d = 4'd0;
        end
      SERVICE: if (wr_eoi) begin
        state_d = IDLE;
        last_d = vec_q;
        vec_d = 4'd0;
      end
      default: begin
        state_d = IDLE;
        vec_d = 4'd0;
      end
    endcase
  end
  // state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q <= '0;
      enable_q <= '0;
      prev_q <= '0;
      data_q <= '0;
      vec_q <= '0;
      last_q <= '0;
      state_q <= IDLE;
    end else begin
      pending_q <= pending_d;
      enable_q <= enable_d;
      prev_q <= i_lines;
      data_q <= data_d;
      vec_q <= vec_d;
      last_q <= last_d;
      state_q <= state_d;
    end
  end
  assign o_data = data_q;
  assign o_int = state_q == REQ;
  assign o_vector = vec_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: scoreboard bench for fixed and rotating irq_sequencer instances
module tb_irq_sequencer;
  localparam logic [15:0] BA = 16'h0420;
  logic clk = 0, rst = 1, we = 0, ack = 0;
  logic [15:0] addr = 0, wdata = 0, lines = 0, rdata, rdata_r;
  logic int_f, int_r;
  logic [3:0] vec_f, vec_r;
  int errors = 0, checks = 0;
  logic [15:0] exp_q[$];
  string tag_q[$];
  always #5 clk = ~clk;
  irq_sequencer #(.BASE_ADDR(BA), .ROTATE(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_addr(addr), .i_data(wdata), .o_data(rdata),
    .i_lines(lines), .i_ack(ack), .o_int(int_f), .o_vector(vec_f));
  irq_sequencer #(.BASE_ADDR(BA), .ROTATE(1'b1)) dut_r (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_addr(addr), .i_data(wdata), .o_data(rdata_r),
    .i_lines(lines), .i_ack(ack), .o_int(int_r), .o_vector(vec_r));
  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string tag, input logic [15:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask
  task automatic pop(input logic [15:0] act);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", act, 16'hxxxx);
    end else chk(tag_q.pop_front(), act, exp_q.pop_front());
  endtask
  task automatic rd(input string tag, input logic [15:0] off, input logic [15:0] exp);
    addr = BA + off;
    push(tag, exp);
    step();
    pop(rdata);
  endtask
  task automatic wr(input logic [15:0] off, input logic [15:0] d);
    we = 1;
    addr = BA + off;
    wdata = d;
    step();
    we = 0;
  endtask
  task automatic pulse(input logic [15:0] v);
    lines = v;
    step();
    lines = 0;
  endtask
  task automatic irq(input string tag, input logic [3:0] vf, input logic [3:0] vr);
    push({tag, "_int"}, 16'd1);
    push({tag, "_vec"}, {12'd0, vf});
    push({tag, "_int_r"}, 16'd1);
    push({tag, "_vec_r"}, {12'd0, vr});
    pop({15'd0, int_f});
    pop({12'd0, vec_f});
    pop({15'd0, int_r});
    pop({12'd0, vec_r});
  endtask
  initial begin
    step();
    step();
    rst = 0;
    push("rst_int", 16'd0);
    pop({15'd0, int_f});
    push("rst_vec", 16'd0);
    pop({12'd0, vec_f});
    push("rst_data", 16'd0);
    pop(rdata);
    rd("rst_pending", 16'd0, 16'h0000);
    // rotating vs fixed: service line 1 so last_serviced = 1, then lines 1 and 6 together
    wr(16'd1, 16'h0042);
    pulse(16'h0002);
    step();
    irq("rr_prime", 4'd1, 4'd1);
    ack = 1;
    step();
    ack = 0;
    wr(16'd3, 16'h0000);
    pulse(16'h0042);
    step();
    irq("rr_first", 4'd1, 4'd6);
    ack = 1;
    step();
    ack = 0;
    wr(16'd3, 16'hBEEF);
    step();
    irq("rr_second", 4'd6, 4'd1);
    rst = 1;
    step();
    rst = 0;
    // fixed priority: lines 5 and 2 together
    wr(16'd1, 16'h00FF);
    pulse(16'h0024);
    push("fp_int_early", 16'd0);
    pop({15'd0, int_f});
    step();
    irq("fp_first", 4'd2, 4'd2);
    ack = 1;
    step();
    ack = 0;
    push("fp_ack_int", 16'd0);
    pop({15'd0, int_f});
    rd("fp_status", 16'd2, 16'h8002);
    wr(16'd3, 16'h0000);
    step();
    irq("fp_next", 4'd5, 4'd5);
    ack = 1;
    step();
    ack = 0;
    wr(16'd3, 16'h0000);
    // withdrawal by W1C while requesting vector 4
    pulse(16'h0010);
    step();
    push("wd_req_vec", 16'd4);
    pop({12'd0, vec_f});
    wr(16'd0, 16'h0010);
    step();
    push("wd_int", 16'd0);
    pop({15'd0, int_f});
    rd("wd_status", 16'd2, 16'h0000);
    // masking
    rst = 1;
    step();
    rst = 0;
    wr(16'd1, 16'h0001);
    pulse(16'h0008);
    step();
    push("mask_int", 16'd0);
    pop({15'd0, int_f});
    rd("mask_pending", 16'd0, 16'h0008);
    wr(16'd1, 16'h0008);
    step();
    push("mask_int_on", 16'd1);
    pop({15'd0, int_f});
    push("mask_vec", 16'd3);
    pop({12'd0, vec_f});
    // set beats W1C on the same bit
    rst = 1;
    step();
    rst = 0;
    pulse(16'h0080);
    step();
    lines = 16'h0080;
    wr(16'd0, 16'h0080);
    lines = 0;
    rd("setwins_pending", 16'd0, 16'h0080);
    // ack wins over enable clear in the same cycle
    wr(16'd1, 16'h0080);
    step();
    push("ackwin_vec", 16'd7);
    pop({12'd0, vec_f});
    ack = 1;
    wr(16'd1, 16'h0000);
    ack = 0;
    rd("ackwin_status", 16'd2, 16'h8007);
    // reset during service
    rst = 1;
    step();
    rst = 0;
    push("rst_svc_int", 16'd0);
    pop({15'd0, int_f});
    rd("rst_svc_status", 16'd2, 16'h0000);
    rd("rst_svc_enable", 16'd1, 16'h0000);
    rd("unmapped", 16'd7, 16'h0000);
    if (exp_q.size() != 0) chk("scoreboard_left", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
